// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared fetch-state encoding, instruction field positions and
//            PC helpers for the MIPS front end.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Fetch state encoding
    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_FULL = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    // Instruction field bit positions
    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int SHAMT_HI = 10;
    localparam int SHAMT_LO = 6;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;
    localparam int IMM16_HI = 15;
    localparam int IMM16_LO = 0;
    localparam int IMM26_HI = 25;
    localparam int IMM26_LO = 0;

    localparam logic [31:0] NOP       = 32'h0000_0000;
    localparam logic [31:0] c_PC_STEP = 32'd4;

    // Sequential PC, wrapping modulo 2^32
    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + c_PC_STEP;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fields.sv
`default_nettype none
// ============================================================================
// Module   : instr_fields
// Brief    : Combinational slicer from a 32-bit instruction word to its raw
//            MIPS fields.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fields
    import mips_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic [15:0] o_imm16,
    output logic [25:0] o_imm26,
    output logic [4:0]  o_shamt,
    output logic [4:0]  o_rs,
    output logic [4:0]  o_rt,
    output logic [4:0]  o_rd,
    output logic [5:0]  o_opcode,
    output logic [5:0]  o_funct
);

    assign o_imm16  = i_instr[IMM16_HI:IMM16_LO];
    assign o_imm26  = i_instr[IMM26_HI:IMM26_LO];
    assign o_shamt  = i_instr[SHAMT_HI:SHAMT_LO];
    assign o_rs     = i_instr[RS_HI:RS_LO];
    assign o_rt     = i_instr[RT_HI:RT_LO];
    assign o_rd     = i_instr[RD_HI:RD_LO];
    assign o_opcode = i_instr[OPC_HI:OPC_LO];
    assign o_funct  = i_instr[FUNCT_HI:FUNCT_LO];

endmodule
`default_nettype wire

// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_unit
// Brief    : Instruction fetch stage: PC, imem req/ack handshake, one-entry
//            skid buffer, redirect handling and decode-side output register.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic [31:0] id_instr,
    output logic [15:0] IMM16_field,
    output logic [25:0] IMM26_field,
    output logic [4:0]  SHAMT_field,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [5:0]  opcode,
    output logic [5:0]  funct
);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_fetch_pc;
    logic [31:0] w_fetch_pc_nxt;
    logic [31:0] r_pending_pc;
    logic [31:0] w_pending_pc_nxt;
    logic [31:0] r_skid_pc;
    logic [31:0] r_skid_instr;
    logic        r_id_valid;
    logic        w_id_valid_nxt;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_instr;

    logic        w_skid_load;
    logic        w_id_load_fetch;
    logic        w_id_load_skid;
    logic        w_slot_free;
    logic [31:0] w_redirect_pc;

    assign w_redirect_pc = redirect_pc & ~32'h0000_0003;
    assign w_slot_free   = !r_id_valid || !stall;

    // Fetch state machine: next state and datapath load enables
    always_comb begin
        w_state_nxt      = r_state;
        w_fetch_pc_nxt   = r_fetch_pc;
        w_pending_pc_nxt = r_pending_pc;
        w_skid_load      = 1'b0;
        w_id_load_fetch  = 1'b0;
        w_id_load_skid   = 1'b0;

        case (r_state)
            S_REQ: begin
                if (imem_ack) begin
                    if (redirect_valid) begin
                        w_fetch_pc_nxt = w_redirect_pc;
                    end else begin
                        w_fetch_pc_nxt = pc_next(r_fetch_pc);
                        if (w_slot_free) begin
                            w_id_load_fetch = 1'b1;
                        end else begin
                            w_skid_load = 1'b1;
                            w_state_nxt = S_FULL;
                        end
                    end
                end else if (redirect_valid) begin
                    w_pending_pc_nxt = w_redirect_pc;
                    w_state_nxt      = S_DROP;
                end
            end

            S_FULL: begin
                if (redirect_valid) begin
                    w_fetch_pc_nxt = w_redirect_pc;
                    w_state_nxt    = S_REQ;
                end else if (!stall) begin
                    w_id_load_skid = 1'b1;
                    w_state_nxt    = S_REQ;
                end
            end

            S_DROP: begin
                // A redirect coinciding with the ack is the newest target
                if (imem_ack) begin
                    w_fetch_pc_nxt = redirect_valid ? w_redirect_pc : r_pending_pc;
                    w_state_nxt    = S_REQ;
                end else if (redirect_valid) begin
                    w_pending_pc_nxt = w_redirect_pc;
                end
            end

            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
    end

    always_comb begin
        w_id_valid_nxt = r_id_valid;
        if (redirect_valid) begin
            w_id_valid_nxt = 1'b0;
        end else if (w_id_load_fetch || w_id_load_skid) begin
            w_id_valid_nxt = 1'b1;
        end else if (!stall) begin
            w_id_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_REQ;
            r_fetch_pc   <= PC_RESET;
            r_pending_pc <= PC_RESET;
        end else begin
            r_state      <= w_state_nxt;
            r_fetch_pc   <= w_fetch_pc_nxt;
            r_pending_pc <= w_pending_pc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_skid_pc    <= 32'h0000_0000;
            r_skid_instr <= NOP;
        end else if (w_skid_load) begin
            r_skid_pc    <= r_fetch_pc;
            r_skid_instr <= imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_valid <= 1'b0;
            r_id_pc    <= 32'h0000_0000;
            r_id_instr <= NOP;
        end else begin
            r_id_valid <= w_id_valid_nxt;
            if (w_id_load_fetch) begin
                r_id_pc    <= r_fetch_pc;
                r_id_instr <= imem_rdata;
            end else if (w_id_load_skid) begin
                r_id_pc    <= r_skid_pc;
                r_id_instr <= r_skid_instr;
            end
        end
    end

    assign imem_req  = !rst && ((r_state == S_REQ) || (r_state == S_DROP));
    assign imem_addr = r_fetch_pc;

    assign id_valid  = r_id_valid;
    assign id_pc     = r_id_pc;
    assign id_pc4    = pc_next(r_id_pc);
    assign id_instr  = r_id_instr;

    instr_fields u_fields (
        .i_instr  (r_id_instr),
        .o_imm16  (IMM16_field),
        .o_imm26  (IMM26_field),
        .o_shamt  (SHAMT_field),
        .o_rs     (rs),
        .o_rt     (rt),
        .o_rd     (rd),
        .o_opcode (opcode),
        .o_funct  (funct)
    );

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch_unit
// Brief    : Self-checking bench for ifetch_unit: vector table, directed
//            redirect/reset sequences and a randomized program-order check.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        id_valid;
    logic [31:0] id_pc, id_pc4, id_instr;
    logic [15:0] IMM16_field;
    logic [25:0] IMM26_field;
    logic [4:0]  SHAMT_field, rs, rt, rd;
    logic [5:0]  opcode, funct;

    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic        w_id_valid;
    logic [31:0] w_id_pc, w_id_pc4, w_id_instr;
    logic [15:0] w_imm16;
    logic [25:0] w_imm26;
    logic [4:0]  w_shamt, w_rs, w_rt, w_rd;
    logic [5:0]  w_opcode, w_funct;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ifetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_pc(id_pc), .id_pc4(id_pc4), .id_instr(id_instr),
        .IMM16_field(IMM16_field), .IMM26_field(IMM26_field), .SHAMT_field(SHAMT_field),
        .rs(rs), .rt(rt), .rd(rd), .opcode(opcode), .funct(funct)
    );

    ifetch_unit #(.PC_RESET(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .id_valid(w_id_valid), .id_pc(w_id_pc), .id_pc4(w_id_pc4), .id_instr(w_id_instr),
        .IMM16_field(w_imm16), .IMM26_field(w_imm26), .SHAMT_field(w_shamt),
        .rs(w_rs), .rt(w_rt), .rd(w_rd), .opcode(w_opcode), .funct(w_funct)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_fields(input logic [31:0] w);
        check("imm16", 32'(IMM16_field), 32'(w[15:0]));
        check("imm26", 32'(IMM26_field), 32'(w[25:0]));
        check("shamt", 32'(SHAMT_field), 32'(w[10:6]));
        check("rs",    32'(rs),          32'(w[25:21]));
        check("rt",    32'(rt),          32'(w[20:16]));
        check("rd",    32'(rd),          32'(w[15:11]));
        check("opc",   32'(opcode),      32'(w[31:26]));
        check("funct", 32'(funct),       32'(w[5:0]));
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h2468_ACE1;
    endfunction

    task automatic do_reset();
        rst = 1'b1; imem_ack = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        ack;
        logic        stl;
        logic        redir;
        logic [31:0] rpc;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        busy, prev_req, prev_ack, prev_stall, prev_redir, prev_valid;
        logic [31:0] prev_addr, prev_pc, prev_instr, exp_pc;
        int          lat, consumed;

        // ack, stall, redirect, redirect_pc | req, addr, id_valid, id_pc
        tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h4};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'hC,   1'b1, 32'h4};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'hC,   1'b1, 32'h4};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'hC,   1'b1, 32'h4};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h8};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 32'h103, 1'b1, 32'h10,  1'b1, 32'hC};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'hC};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h100};

        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req",    32'(imem_req), 32'h0);
        check("rst_valid",  32'(id_valid), 32'h0);
        check("rst_instr",  id_instr,      32'h0);
        check("rst_pc",     id_pc,         32'h0);
        check("rst_pc4",    id_pc4,        32'h4);
        check_fields(32'h0);
        rst = 1'b0;

        // Vector table: 1-cycle acks, skid under stall, redirect with ack
        for (int i = 0; i < 10; i++) begin
            imem_ack = tbl[i].ack; stall = tbl[i].stl;
            redirect_valid = tbl[i].redir; redirect_pc = tbl[i].rpc;
            imem_rdata = 32'h2008_0005;
            #1;
            check($sformatf("v%0d_req", i),   32'(imem_req), 32'(tbl[i].exp_req));
            check($sformatf("v%0d_addr", i),  imem_addr,     tbl[i].exp_addr);
            check($sformatf("v%0d_valid", i), 32'(id_valid), 32'(tbl[i].exp_valid));
            check($sformatf("v%0d_pc", i),    id_pc,         tbl[i].exp_pc);
            if (tbl[i].exp_valid) begin
                check($sformatf("v%0d_instr", i), id_instr, 32'h2008_0005);
                check($sformatf("v%0d_pc4", i),   id_pc4,   tbl[i].exp_pc + 32'd4);
            end
            if (i == 1) begin
                check("v1_imm16", 32'(IMM16_field), 32'h5);
                check("v1_rt",    32'(rt),          32'h8);
                check("v1_opc",   32'(opcode),      32'h8);
                check("wrap_pc1", w_id_pc,          32'hFFFF_FFF8);
            end
            if (i < 3) check($sformatf("wrap_addr%0d", i), w_imem_addr, 32'hFFFF_FFF8 + 32'(4 * i));
            if (i == 2) begin
                check("wrap_pc2",  w_id_pc,  32'hFFFF_FFFC);
                check("wrap_pc4",  w_id_pc4, 32'h0);
            end
            @(negedge clk);
        end
        imem_ack = 1'b0; stall = 1'b0; redirect_valid = 1'b0;

        // Redirect while a 3-cycle fetch is outstanding
        do_reset();
        imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0202;
        #1 check("drop_addr0", imem_addr, 32'h0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1 check("drop_req1", 32'(imem_req), 32'h1);
        check("drop_addr1", imem_addr, 32'h0);
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #1 check("drop_addr2", imem_addr, 32'h0);
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = 32'h0123_4567;
        #1 check("drop_new_addr", imem_addr, 32'h200);
        check("drop_valid0", 32'(id_valid), 32'h0);
        @(negedge clk);
        imem_ack = 1'b0;
        #1 check("drop_valid1", 32'(id_valid), 32'h1);
        check("drop_pc", id_pc, 32'h200);
        check("drop_instr", id_instr, 32'h0123_4567);
        check_fields(32'h0123_4567);

        // Reset asserted while in the drop state
        do_reset();
        imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h300;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1 check("rd_req_pre", 32'(imem_req), 32'h1);
        rst = 1'b1;
        #1 check("rd_req_rst", 32'(imem_req), 32'h0);
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        #1 check("rd_req_hold", 32'(imem_req), 32'h0);
        check("rd_valid", 32'(id_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0; imem_ack = 1'b0;
        #1 check("rd_restart_req", 32'(imem_req), 32'h1);
        check("rd_restart_addr", imem_addr, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
        @(negedge clk);
        imem_ack = 1'b0;
        #1 check("rd_first_valid", 32'(id_valid), 32'h1);
        check("rd_first_pc", id_pc, 32'h0);
        check("rd_first_instr", id_instr, 32'h2008_0005);

        // Randomized run against a program-order reference
        do_reset();
        busy = 1'b0; lat = 0; exp_pc = 32'h0; consumed = 0;
        prev_req = 1'b0; prev_ack = 1'b0; prev_stall = 1'b0; prev_redir = 1'b0;
        prev_valid = 1'b0; prev_addr = 32'h0; prev_pc = 32'h0; prev_instr = 32'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc > 0) begin
                if (prev_req && !prev_ack) begin
                    check("rnd_req_held",  32'(imem_req), 32'h1);
                    check("rnd_addr_held", imem_addr,     prev_addr);
                end
                if (prev_redir) begin
                    check("rnd_redir_kill", 32'(id_valid), 32'h0);
                end else if (prev_stall && prev_valid) begin
                    check("rnd_stall_valid", 32'(id_valid), 32'h1);
                    check("rnd_stall_pc",    id_pc,         prev_pc);
                    check("rnd_stall_instr", id_instr,      prev_instr);
                end
            end

            stall          = ($urandom_range(0, 99) < 30);
            redirect_valid = ($urandom_range(0, 99) < 7);
            redirect_pc    = $urandom_range(0, 1023);
            imem_ack       = 1'b0;
            imem_rdata     = $urandom;
            if (imem_req) begin
                if (!busy) begin
                    busy = 1'b1;
                    lat  = $urandom_range(0, 3);
                end
                if (lat == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = word_of(imem_addr);
                    busy       = 1'b0;
                end else begin
                    lat--;
                end
            end

            if (id_valid && !stall) begin
                check("rnd_seq_pc",    id_pc,    exp_pc);
                check("rnd_seq_instr", id_instr, word_of(exp_pc));
                check("rnd_seq_pc4",   id_pc4,   exp_pc + 32'd4);
                check_fields(word_of(exp_pc));
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            if (redirect_valid) exp_pc = redirect_pc & ~32'h3;

            prev_req = imem_req; prev_ack = imem_ack; prev_addr = imem_addr;
            prev_stall = stall; prev_redir = redirect_valid;
            prev_valid = id_valid; prev_pc = id_pc; prev_instr = id_instr;
            @(negedge clk);
        end
        check("rnd_progress", 32'(consumed > 100), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
